// File: rtl/ce_clock_gen.sv
// ce_clock_gen
// Multi-channel NCO clock-enable generator running in the core (PLL CLKOP)
// clock domain. Each channel owns a phase accumulator and a programmable
// increment; the accumulator carry becomes a one-clk-wide enable strobe
// at f_clk * inc / 2^ACC_WIDTH. A per-channel lock flag rises once
// LOCK_PULSES consecutive strobes have been produced since the channel
// was last written, enabled or reset.
//
// Optional build macro CE_CLOCK_GEN_TOGGLE_EN adds the ce_tog output:
// one flop per channel toggling on every strobe (50% duty at f_ce/2).
//
// All outputs come straight from flops; there is no combinational path
// from any input to any output.
module ce_clock_gen #(
  parameter int NUM_CH      = 4,
  parameter int ACC_WIDTH   = 24,
  parameter int LOCK_PULSES = 4,
  localparam int CHW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 wr_en,
  input  logic [CHW-1:0]       wr_ch,
  input  logic [ACC_WIDTH-1:0] wr_data,
  input  logic [NUM_CH-1:0]    ch_en,
  input  logic                 sync,
  output logic [NUM_CH-1:0]    ce,
`ifdef CE_CLOCK_GEN_TOGGLE_EN
  output logic [NUM_CH-1:0]    ce_tog,
  output logic [NUM_CH-1:0]    lock
`else
  output logic [NUM_CH-1:0]    lock
`endif
);

  localparam logic [7:0] LOCK_TC   = 8'(LOCK_PULSES);
  localparam logic [7:0] LOCK_LAST = 8'(LOCK_PULSES - 1);

  logic [ACC_WIDTH-1:0] r_acc [NUM_CH];
  logic [ACC_WIDTH-1:0] r_inc [NUM_CH];
  logic [7:0]           r_cnt [NUM_CH];
  logic [NUM_CH-1:0]    r_ce;
  logic [NUM_CH-1:0]    r_lock;

  logic [ACC_WIDTH:0]   w_sum [NUM_CH];
  logic [NUM_CH-1:0]    w_wr_hit;

  // Per-channel add with carry, and write decode (out-of-range wr_ch never matches).
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_sum[i]    = {1'b0, r_acc[i]} + {1'b0, r_inc[i]};
      w_wr_hit[i] = wr_en && (wr_ch == CHW'(i));
    end
  end

  // Accumulators, increments, strobes and lock tracking; write beats sync beats disable.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_acc[i] <= '0;
        r_inc[i] <= '0;
        r_cnt[i] <= '0;
      end
      r_ce   <= '0;
      r_lock <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_wr_hit[i]) begin
          r_inc[i]  <= wr_data;
          r_acc[i]  <= '0;
          r_ce[i]   <= 1'b0;
          r_lock[i] <= 1'b0;
          r_cnt[i]  <= '0;
        end else if (sync) begin
          // Phase alignment keeps lock history unless the channel is also stopped.
          r_acc[i] <= '0;
          r_ce[i]  <= 1'b0;
          if (!ch_en[i]) begin
            r_lock[i] <= 1'b0;
            r_cnt[i]  <= '0;
          end
        end else if (!ch_en[i]) begin
          r_ce[i]   <= 1'b0;
          r_lock[i] <= 1'b0;
          r_cnt[i]  <= '0;
        end else begin
          r_acc[i] <= w_sum[i][ACC_WIDTH-1:0];
          r_ce[i]  <= w_sum[i][ACC_WIDTH];
          // Counter tracks strobes in the same cycle they appear on ce, so
          // lock rises together with the LOCK_PULSES-th strobe.
          if (w_sum[i][ACC_WIDTH] && (r_cnt[i] != LOCK_TC)) begin
            r_cnt[i] <= r_cnt[i] + 8'd1;
            if (r_cnt[i] == LOCK_LAST) begin
              r_lock[i] <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign ce   = r_ce;
  assign lock = r_lock;

`ifdef CE_CLOCK_GEN_TOGGLE_EN
  logic [NUM_CH-1:0] r_tog;

  // Square-wave outputs: flip on every visible strobe, realigned by write or sync.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_tog <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_wr_hit[i] || sync) begin
          r_tog[i] <= 1'b0;
        end else begin
          r_tog[i] <= r_tog[i] ^ r_ce[i];
        end
      end
    end
  end

  assign ce_tog = r_tog;
`endif

endmodule

// File: tb/tb_ce_clock_gen.sv
// Scoreboard bench for ce_clock_gen. The stimulus process drives one set of
// inputs per cycle, advances a phase-arithmetic reference model and queues
// the expected ce/lock (and ce_tog) for the following edge; a monitor pops
// and compares after every rising edge. A few rate checks use numbers
// derived directly from f_ce = f_clk * inc / 2^ACC_WIDTH.
module tb_ce_clock_gen;

  localparam int NUM_CH      = 5;
  localparam int ACC_WIDTH   = 24;
  localparam int LOCK_PULSES = 4;
  localparam int CHW         = 3;
  localparam longint MOD     = longint'(1) << ACC_WIDTH;

  logic                 clk;
  logic                 reset_n;
  logic                 wr_en;
  logic [CHW-1:0]       wr_ch;
  logic [ACC_WIDTH-1:0] wr_data;
  logic [NUM_CH-1:0]    ch_en;
  logic                 sync;
  logic [NUM_CH-1:0]    ce;
  logic [NUM_CH-1:0]    lock;
  logic [NUM_CH-1:0]    ce_tog;

  ce_clock_gen #(
    .NUM_CH      (NUM_CH),
    .ACC_WIDTH   (ACC_WIDTH),
    .LOCK_PULSES (LOCK_PULSES)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_en),
    .wr_ch   (wr_ch),
    .wr_data (wr_data),
    .ch_en   (ch_en),
    .sync    (sync),
    .ce      (ce),
`ifdef CE_CLOCK_GEN_TOGGLE_EN
    .ce_tog  (ce_tog),
`endif
    .lock    (lock)
  );

`ifndef CE_CLOCK_GEN_TOGGLE_EN
  assign ce_tog = '0;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [NUM_CH-1:0] ce;
    logic [NUM_CH-1:0] lock;
    logic [NUM_CH-1:0] tog;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model state: phase as a plain integer, pulse count unbounded.
  longint m_ph     [NUM_CH];
  longint m_inc    [NUM_CH];
  int     m_pulses [NUM_CH];
  bit     m_ce     [NUM_CH];
  bit     m_tog    [NUM_CH];

  function automatic void model(input bit rst_n, input bit wr, input int wch,
                                input logic [ACC_WIDTH-1:0] wd,
                                input logic [NUM_CH-1:0] en, input bit syn);
    exp_t e;
    e = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      bit prev_ce;
      prev_ce = m_ce[c];
      if (!rst_n) begin
        m_ph[c] = 0; m_inc[c] = 0; m_pulses[c] = 0; m_ce[c] = 0; m_tog[c] = 0;
      end else if (wr && wch == c) begin
        m_inc[c] = longint'(wd); m_ph[c] = 0; m_ce[c] = 0; m_pulses[c] = 0; m_tog[c] = 0;
      end else if (syn) begin
        m_ph[c] = 0; m_ce[c] = 0; m_tog[c] = 0;
        if (!en[c]) m_pulses[c] = 0;
      end else begin
        m_tog[c] = m_tog[c] ^ prev_ce;
        if (!en[c]) begin
          m_ce[c] = 0; m_pulses[c] = 0;
        end else begin
          m_ph[c] = m_ph[c] + m_inc[c];
          m_ce[c] = (m_ph[c] >= MOD);
          m_ph[c] = m_ph[c] % MOD;
          if (m_ce[c]) m_pulses[c] = m_pulses[c] + 1;
        end
      end
      e.ce[c]   = m_ce[c];
      e.lock[c] = (m_pulses[c] >= LOCK_PULSES);
      e.tog[c]  = m_tog[c];
    end
    q.push_back(e);
  endfunction

  task automatic step(input bit rst_n, input bit wr, input int wch,
                      input logic [ACC_WIDTH-1:0] wd,
                      input logic [NUM_CH-1:0] en, input bit syn);
    reset_n = rst_n;
    wr_en   = wr;
    wr_ch   = CHW'(wch);
    wr_data = wd;
    ch_en   = en;
    sync    = syn;
    model(rst_n, wr, wch, wd, en, syn);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic [NUM_CH-1:0] en);
    for (int k = 0; k < n; k++) step(1'b1, 1'b0, 0, '0, en, 1'b0);
  endtask

  function automatic logic [ACC_WIDTH-1:0] pick_inc();
    logic [ACC_WIDTH-1:0] v;
    case ($urandom_range(0, 5))
      0: v = '0;
      1: v = 24'h400000;
      2: v = 24'h800000;
      3: v = 24'h555555;
      4: v = '1;
      default: v = ACC_WIDTH'($urandom);
    endcase
    return v;
  endfunction

  // Monitor: one comparison set per rising edge whenever an expectation is queued.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (ce !== e.ce) begin
          failures++;
          $display("FAIL ce t=%0t actual=%b expected=%b", $time, ce, e.ce);
        end
        checks++;
        if (lock !== e.lock) begin
          failures++;
          $display("FAIL lock t=%0t actual=%b expected=%b", $time, lock, e.lock);
        end
`ifdef CE_CLOCK_GEN_TOGGLE_EN
        checks++;
        if (ce_tog !== e.tog) begin
          failures++;
          $display("FAIL ce_tog t=%0t actual=%b expected=%b", $time, ce_tog, e.tog);
        end
`endif
      end
    end
  end

  initial begin
    int n0, n1, n2, n3, n4, wait_cyc;
    int tog_edges;
    logic prev_tog;

    // Reset with all inputs low, then 100 quiet cycles.
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 0, '0, '0, 1'b0);
    idle(100, '0);

    // Channel 0 at quarter rate; lock after four strobes.
    step(1'b1, 1'b1, 0, 24'h400000, 5'b00001, 1'b0);
    n0 = 0;
    for (int k = 0; k < 40; k++) begin
      step(1'b1, 1'b0, 0, '0, 5'b00001, 1'b0);
      n0 += int'(ce[0]);
    end
    checks++;
    if (n0 != 10) begin
      failures++;
      $display("FAIL ch0_rate actual=%0d expected=10", n0);
    end

    // Channels 1 and 2: half rate and one third rate.
    step(1'b1, 1'b1, 1, 24'h800000, 5'b00111, 1'b0);
    step(1'b1, 1'b1, 2, 24'h555555, 5'b00111, 1'b0);
    n1 = 0;
    n2 = 0;
    for (int k = 0; k < 3000; k++) begin
      step(1'b1, 1'b0, 0, '0, 5'b00111, 1'b0);
      n1 += int'(ce[1]);
      n2 += int'(ce[2]);
    end
    checks++;
    if (n1 < 1499 || n1 > 1501) begin
      failures++;
      $display("FAIL ch1_rate actual=%0d expected=1500+-1", n1);
    end
    checks++;
    if (n2 < 999 || n2 > 1001) begin
      failures++;
      $display("FAIL ch2_rate actual=%0d expected=1000+-1", n2);
    end

    // Drop ch_en[0] for three cycles, then restore.
    step(1'b1, 1'b0, 0, '0, 5'b00110, 1'b0);
    checks++;
    if (lock[0] !== 1'b0) begin
      failures++;
      $display("FAIL lock0_drop actual=%b expected=0", lock[0]);
    end
    idle(2, 5'b00110);
    idle(24, 5'b00111);

    // Sync with channels at mixed phases.
    idle(3, 5'b00111);
    step(1'b1, 1'b0, 0, '0, 5'b00111, 1'b1);
    idle(16, 5'b00111);

    // Out-of-range writes must leave every channel untouched.
    step(1'b1, 1'b1, 5, 24'h123456, 5'b00111, 1'b0);
    step(1'b1, 1'b1, 7, 24'hFFFFFF, 5'b00111, 1'b0);
    idle(8, 5'b00111);

    // Channel 3 at inc=0 never strobes.
    step(1'b1, 1'b1, 3, 24'h000000, 5'b01111, 1'b0);
    n3 = 0;
    for (int k = 0; k < 50; k++) begin
      step(1'b1, 1'b0, 0, '0, 5'b01111, 1'b0);
      n3 += int'(ce[3]) + int'(lock[3]);
    end
    checks++;
    if (n3 != 0) begin
      failures++;
      $display("FAIL ch3_zero actual=%0d expected=0", n3);
    end

    // Channel 4 at maximum increment: only the first add has no carry.
    step(1'b1, 1'b1, 4, 24'hFFFFFF, 5'b11111, 1'b0);
    n4 = 0;
    for (int k = 0; k < 40; k++) begin
      step(1'b1, 1'b0, 0, '0, 5'b11111, 1'b0);
      n4 += int'(ce[4]);
    end
    checks++;
    if (n4 != 39) begin
      failures++;
      $display("FAIL ch4_max actual=%0d expected=39", n4);
    end

`ifdef CE_CLOCK_GEN_TOGGLE_EN
    // Channel 0 at quarter rate gives a toggle period of 8.
    step(1'b1, 1'b1, 0, 24'h400000, 5'b11111, 1'b0);
    tog_edges = 0;
    prev_tog = 1'b0;
    for (int k = 0; k < 64; k++) begin
      step(1'b1, 1'b0, 0, '0, 5'b11111, 1'b0);
      if (ce_tog[0] && !prev_tog) tog_edges++;
      prev_tog = ce_tog[0];
    end
    checks++;
    if (tog_edges != 8) begin
      failures++;
      $display("FAIL tog0_period actual=%0d expected=8", tog_edges);
    end
`else
    tog_edges = 0;
    prev_tog = 1'b0;
`endif

    // Randomized traffic: writes, enables, syncs and occasional resets.
    for (int k = 0; k < 1500; k++) begin
      logic [NUM_CH-1:0] en;
      bit wr, syn, rn;
      en  = NUM_CH'($urandom) | NUM_CH'($urandom);
      wr  = ($urandom_range(0, 11) == 0);
      syn = ($urandom_range(0, 39) == 0);
      rn  = ($urandom_range(0, 299) != 0);
      step(rn, wr, $urandom_range(0, 7), pick_inc(), en, syn);
    end

    // Drain the scoreboard.
    wait_cyc = 0;
    while (q.size() > 0 && wait_cyc < 10) begin
      @(negedge clk);
      wait_cyc++;
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d expected=0 pending", q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
